// File: rtl/ssio_ddr_out_framer.sv
// Transmit framer for a source-synchronous DDR link: stream words -> rising/falling edge data, control and forwarded-clock pairs.
// Latency: a word written into the skid buffer at one clk edge is driven on output_d1/d2 at the next edge; all outputs registered.
// Backpressure: s_ready is registered; it is withheld during training and whenever the 2-entry skid buffer could overflow.
module ssio_ddr_out_framer #(
    parameter int               WIDTH        = 4,
    parameter int               TRAIN_CYCLES = 16,
    parameter logic [WIDTH-1:0] IDLE_VALUE   = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*WIDTH-1:0]   s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic                 train_req,
    output logic                 train_busy,
    output logic [WIDTH-1:0]     output_d1,
    output logic [WIDTH-1:0]     output_d2,
    output logic                 output_ctl1,
    output logic                 output_ctl2,
    output logic                 output_clk1,
    output logic                 output_clk2
);

    localparam int            CW   = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TRAIN_CYCLES - 1);

    typedef enum logic {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_buf0;   // head of the skid buffer
    logic [2*WIDTH-1:0]   r_buf1;
    logic [1:0]           r_occ;
    logic                 r_s_ready;
    logic                 r_busy;
    logic [WIDTH-1:0]     r_d1;
    logic [WIDTH-1:0]     r_d2;
    logic                 r_ctl1;
    logic                 r_ctl2;
    logic                 r_clk1;
    logic                 r_clk2;

    state_t               w_state_next;
    logic [CW-1:0]        w_cnt_next;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_occ_next;
    logic                 w_ready_next;
    logic [WIDTH-1:0]     w_d1;
    logic [WIDTH-1:0]     w_d2;
    logic                 w_ctl1;
    logic                 w_ctl2;
    logic                 w_busy;

    // Buffer handshakes: pops only happen in RUN, so words survive a training burst.
    assign w_push = s_valid && r_s_ready;
    assign w_pop  = (r_state == ST_RUN) && (r_occ != 2'd0);

    // Occupancy after this cycle's push/pop
    always_comb begin
        w_occ_next = r_occ;
        case ({w_push, w_pop})
            2'b10:   w_occ_next = r_occ + 2'd1;
            2'b01:   w_occ_next = r_occ - 2'd1;
            default: w_occ_next = r_occ;
        endcase
    end

    // Ready for next cycle: only when RUN continues and one slot is guaranteed free
    assign w_ready_next = (w_state_next == ST_RUN) && !train_req && (w_occ_next <= 2'd1);

    // State and training counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_TRAIN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: a burst is always exactly TRAIN_CYCLES long; requests inside a burst are ignored
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_TRAIN: begin
                if (r_cnt == LAST) begin
                    w_state_next = ST_RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (train_req) begin
                    w_state_next = ST_TRAIN;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_TRAIN;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Output decode for the symbol launched at the coming edge
    always_comb begin
        w_d1   = IDLE_VALUE;
        w_d2   = IDLE_VALUE;
        w_ctl1 = 1'b0;
        w_ctl2 = 1'b0;
        w_busy = 1'b0;
        if (r_state == ST_TRAIN) begin
            w_d1   = '1;
            w_d2   = '0;
            w_ctl1 = 1'b1;
            w_busy = 1'b1;
        end else if (w_pop) begin
            w_d1   = r_buf0[WIDTH-1:0];
            w_d2   = r_buf0[2*WIDTH-1:WIDTH];
            w_ctl1 = 1'b1;
            w_ctl2 = 1'b1;
        end
    end

    // Skid buffer storage: pop shifts toward the head, push lands in the first free slot after the shift
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_occ  <= 2'd0;
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            r_occ <= w_occ_next;
            if (w_pop) begin
                r_buf0 <= r_buf1;
            end
            if (w_push) begin
                if (w_occ_next == 2'd2) begin
                    r_buf1 <= s_data;
                end else begin
                    r_buf0 <= s_data;
                end
            end
        end
    end

    // Registered outputs, forwarded clock free-running once out of reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s_ready <= 1'b0;
            r_busy    <= 1'b1;
            r_d1      <= IDLE_VALUE;
            r_d2      <= IDLE_VALUE;
            r_ctl1    <= 1'b0;
            r_ctl2    <= 1'b0;
            r_clk1    <= 1'b0;
            r_clk2    <= 1'b0;
        end else begin
            r_s_ready <= w_ready_next;
            r_busy    <= w_busy;
            r_d1      <= w_d1;
            r_d2      <= w_d2;
            r_ctl1    <= w_ctl1;
            r_ctl2    <= w_ctl2;
            r_clk1    <= 1'b1;
            r_clk2    <= 1'b0;
        end
    end

    assign s_ready     = r_s_ready;
    assign train_busy  = r_busy;
    assign output_d1   = r_d1;
    assign output_d2   = r_d2;
    assign output_ctl1 = r_ctl1;
    assign output_ctl2 = r_ctl2;
    assign output_clk1 = r_clk1;
    assign output_clk2 = r_clk2;

endmodule

// File: tb/tb_ssio_ddr_out_framer.sv
// Bench for ssio_ddr_out_framer: fixed vector table, directed training/reset sequences, randomized run against a queue model.
// Latency: compares outputs 1 time unit after every rising clk edge.
// Backpressure: stimulus honours s_ready; the model flags any push into a full buffer.
module tb_ssio_ddr_out_framer;

    localparam int TC = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       train_req;
    logic       train_busy;
    logic [3:0] output_d1;
    logic [3:0] output_d2;
    logic       output_ctl1;
    logic       output_ctl2;
    logic       output_clk1;
    logic       output_clk2;

    ssio_ddr_out_framer #(.WIDTH(4), .TRAIN_CYCLES(TC), .IDLE_VALUE(4'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .train_req(train_req), .train_busy(train_busy),
        .output_d1(output_d1), .output_d2(output_d2),
        .output_ctl1(output_ctl1), .output_ctl2(output_ctl2),
        .output_clk1(output_clk1), .output_clk2(output_clk2)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: training cycles still to send, and an ordered queue of accepted words
    int         m_left;
    logic [7:0] m_q[$];
    bit         m_rdy;
    logic [3:0] e_d1, e_d2;
    logic [1:0] e_ctl;     // {ctl2, ctl1}
    logic [1:0] e_clk;     // {clk1, clk2}
    bit         e_busy;

    logic [7:0] sent[$];
    logic [7:0] recv[$];
    bit         auto_inc = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [13:0] outs();
        return {output_d2, output_d1, output_ctl2, output_ctl1, output_clk1, output_clk2, s_ready, train_busy};
    endfunction

    task automatic model_step();
        bit         push;
        logic [7:0] w;
        if (!rst_n) begin
            m_left = TC; m_q.delete(); m_rdy = 1'b0;
            e_d1 = 4'h0; e_d2 = 4'h0; e_ctl = 2'b00; e_clk = 2'b00; e_busy = 1'b1;
            return;
        end
        push  = s_valid && m_rdy;
        if (push && m_q.size() >= 2) chk("overflow_push", 1, 0);
        e_clk = 2'b10;
        if (m_left > 0) begin
            e_d1 = 4'hF; e_d2 = 4'h0; e_ctl = 2'b01; e_busy = 1'b1;
            m_left--;
        end else begin
            e_busy = 1'b0;
            if (m_q.size() > 0) begin
                w = m_q.pop_front();
                e_d1 = w[3:0]; e_d2 = w[7:4]; e_ctl = 2'b11;
            end else begin
                e_d1 = 4'h0; e_d2 = 4'h0; e_ctl = 2'b00;
            end
            if (train_req) m_left = TC;
        end
        if (push) m_q.push_back(s_data);
        m_rdy = (m_left == 0) && !train_req && (m_q.size() <= 1);
    endtask

    task automatic tick();
        bit acc;
        acc = s_valid && s_ready && rst_n;
        @(posedge clk);
        model_step();
        #1;
        chk("model", {18'd0, outs()}, {18'd0, e_d2, e_d1, e_ctl, e_clk, m_rdy, e_busy});
        if (acc) begin
            sent.push_back(s_data);
            if (auto_inc) s_data = s_data + 8'd1;
        end
        if (output_ctl1 && output_ctl2) recv.push_back({output_d2, output_d1});
    endtask

    // Ticks until train_busy drops, returning how many ticks showed it high
    task automatic count_busy(output int n);
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (!train_busy) return;
            n++;
        end
        chk("busy_timeout", 1, 0);
    endtask

    task automatic check_lists(input string name);
        chk({name, "_count"}, recv.size(), sent.size());
        for (int i = 0; i < sent.size() && i < recv.size(); i++)
            chk({name, "_word"}, recv[i], sent[i]);
    endtask

    typedef struct {
        logic       vld;
        logic [7:0] dat;
        logic [3:0] d1, d2;
        logic [1:0] ctl;
        logic       rdy;
    } vec_t;

    vec_t vt[8];
    int   nb;

    initial begin
        // inputs before edge -> outputs after edge, starting from RUN with an empty buffer
        vt[0] = '{1'b1, 8'hA5, 4'h0, 4'h0, 2'b00, 1'b1};
        vt[1] = '{1'b0, 8'h00, 4'h5, 4'hA, 2'b11, 1'b1};
        vt[2] = '{1'b0, 8'h00, 4'h0, 4'h0, 2'b00, 1'b1};
        vt[3] = '{1'b1, 8'h01, 4'h0, 4'h0, 2'b00, 1'b1};
        vt[4] = '{1'b1, 8'h02, 4'h1, 4'h0, 2'b11, 1'b1};
        vt[5] = '{1'b1, 8'h03, 4'h2, 4'h0, 2'b11, 1'b1};
        vt[6] = '{1'b0, 8'h00, 4'h3, 4'h0, 2'b11, 1'b1};
        vt[7] = '{1'b0, 8'h00, 4'h0, 4'h0, 2'b00, 1'b1};

        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; train_req = 1'b0;
        tick(); tick();
        chk("reset_outs", outs(), 14'b0000_0000_00_00_0_1);

        // Training burst after reset release
        rst_n = 1'b1;
        for (int i = 0; i < TC; i++) begin
            tick();
            chk("train_pattern", outs(), {4'h0, 4'hF, 2'b01, 2'b10, (i == TC - 1), 1'b1});
        end
        tick();
        chk("first_idle", outs(), {4'h0, 4'h0, 2'b00, 2'b10, 1'b1, 1'b0});

        // Fixed vector table: single word latency and back-to-back stream
        for (int i = 0; i < 8; i++) begin
            s_valid = vt[i].vld; s_data = vt[i].dat;
            tick();
            chk($sformatf("vec%0d", i), outs(),
                {vt[i].d2, vt[i].d1, vt[i].ctl, 2'b10, vt[i].rdy, 1'b0});
        end

        // Training requested mid-stream: in-flight words held and sent afterwards in order
        sent.delete(); recv.delete();
        auto_inc = 1'b1; s_data = 8'h40; s_valid = 1'b1;
        repeat (5) tick();
        train_req = 1'b1; tick(); train_req = 1'b0;
        chk("ready_drop", s_ready, 1'b0);
        count_busy(nb);
        chk("train_len_req", nb, TC);
        repeat (5) tick();
        s_valid = 1'b0;
        repeat (4) tick();
        check_lists("stream_train");

        // Second request inside a burst does not extend it
        train_req = 1'b1; tick(); train_req = 1'b0;
        nb = 0;
        repeat (4) begin tick(); if (train_busy) nb++; end
        train_req = 1'b1; tick(); if (train_busy) nb++;
        train_req = 1'b0;
        begin
            int rest;
            count_busy(rest);
            chk("train_len_rereq", nb + rest, TC);
        end

        // One-cycle reset during a data burst discards buffered words
        s_valid = 1'b1; s_data = 8'h80;
        repeat (3) tick();
        rst_n = 1'b0; s_valid = 1'b0; tick(); rst_n = 1'b1;
        chk("midburst_reset", outs(), 14'b0000_0000_00_00_0_1);
        sent.delete(); recv.delete();
        count_busy(nb);
        chk("train_len_reset", nb, TC);
        repeat (4) tick();
        chk("no_stale_words", recv.size(), 0);

        // Randomized run against the model
        auto_inc = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            s_valid   = ($urandom_range(0, 1) == 1);
            s_data    = 8'($urandom);
            train_req = ($urandom_range(0, 49) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
